// File: rtl/counter_sweep_pkg.sv
// Shared constants for the counter sweep sequencer: state encoding and default widths.
package counter_sweep_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned REP_W_DEF = 4;
    localparam int unsigned ST_W      = 3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SEEK   = 3'd1;
    localparam logic [2:0] ST_UP     = 3'd2;
    localparam logic [2:0] ST_DOWN   = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;
    localparam logic [2:0] ST_DWELL  = 3'd5;

endpackage

// File: rtl/counter_sweep_dwell_tmr.sv
// Loadable down-counter with a zero flag; times the turnaround dwell of the sweep sequencer.
module counter_sweep_dwell_tmr #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Triangle-sweep sequencer driving an external up/down counter (lo->hi->lo, reps times).
// Optional per-turnaround dwell is enabled by defining COUNTER_SWEEP_DWELL_EN.
module counter_sweep_ctrl
    import counter_sweep_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned REP_W = REP_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_lo,
    input  logic [WIDTH-1:0] cmd_hi,
    input  logic [REP_W-1:0] cmd_reps,
`ifdef COUNTER_SWEEP_DWELL_EN
    input  logic [WIDTH-1:0] cmd_dwell,
`endif
    input  logic             abort,
    input  logic [WIDTH-1:0] cnt_val,
    output logic             cnt_en,
    output logic             cnt_up,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [REP_W-1:0] sweep_cnt
);

    logic [ST_W-1:0]  state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [REP_W-1:0] reps_q, reps_d;
    logic [REP_W-1:0] sweep_cnt_q, sweep_cnt_d;
    logic             err_q, err_d;
    logic             en_c, up_c;
    logic             turn_c;
    logic [ST_W-1:0]  turn_tgt_c;

`ifdef COUNTER_SWEEP_DWELL_EN
    logic [WIDTH-1:0] dwell_q, dwell_d;
    logic [ST_W-1:0]  ret_q, ret_d;
    logic             tmr_load_c, tmr_dec_c, tmr_zero;

    counter_sweep_dwell_tmr #(.WIDTH(WIDTH)) u_dwell_tmr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load_c),
        .load_val_i (dwell_q - WIDTH'(1)),
        .dec_i      (tmr_dec_c),
        .zero_o     (tmr_zero)
    );
`endif

    // Next state plus Mealy counter controls, so the counter halts on the exact compare cycle.
    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        reps_d      = reps_q;
        sweep_cnt_d = sweep_cnt_q;
        err_d       = err_q;
        en_c        = 1'b0;
        up_c        = 1'b1;
        turn_c      = 1'b0;
        turn_tgt_c  = ST_UP;
`ifdef COUNTER_SWEEP_DWELL_EN
        dwell_d     = dwell_q;
        ret_d       = ret_q;
        tmr_load_c  = 1'b0;
        tmr_dec_c   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    lo_d        = cmd_lo;
                    hi_d        = cmd_hi;
                    reps_d      = cmd_reps;
                    sweep_cnt_d = '0;
                    err_d       = (cmd_lo >= cmd_hi);
                    state_d     = (cmd_lo >= cmd_hi) ? ST_FINISH : ST_SEEK;
`ifdef COUNTER_SWEEP_DWELL_EN
                    dwell_d     = cmd_dwell;
`endif
                end
            end
            ST_SEEK: begin
                if (abort) begin
                    state_d = ST_FINISH;
                    err_d   = 1'b1;
                end else if (cnt_val == lo_q) begin
                    state_d = ST_UP;
                end else begin
                    en_c = 1'b1;
                    up_c = (cnt_val < lo_q);
                end
            end
            ST_UP: begin
                if (abort) begin
                    state_d = ST_FINISH;
                    err_d   = 1'b1;
                end else if (cnt_val < hi_q) begin
                    en_c = 1'b1;
                end else begin
                    turn_c     = 1'b1;
                    turn_tgt_c = ST_DOWN;
                end
            end
            ST_DOWN: begin
                // Abort wins over a sweep completing in the same cycle.
                if (abort) begin
                    state_d = ST_FINISH;
                    err_d   = 1'b1;
                end else if (cnt_val > lo_q) begin
                    en_c = 1'b1;
                    up_c = 1'b0;
                end else begin
                    sweep_cnt_d = sweep_cnt_q + REP_W'(1);
                    turn_c      = 1'b1;
                    turn_tgt_c  = ((reps_q != '0) && (sweep_cnt_d == reps_q)) ? ST_FINISH : ST_UP;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
`ifdef COUNTER_SWEEP_DWELL_EN
            ST_DWELL: begin
                if (abort) begin
                    state_d = ST_FINISH;
                    err_d   = 1'b1;
                end else if (tmr_zero) begin
                    state_d = ret_q;
                end else begin
                    tmr_dec_c = 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (turn_c) begin
`ifdef COUNTER_SWEEP_DWELL_EN
            if (dwell_q != '0) begin
                state_d    = ST_DWELL;
                ret_d      = turn_tgt_c;
                tmr_load_c = 1'b1;
            end else begin
                state_d = turn_tgt_c;
            end
`else
            state_d = turn_tgt_c;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lo_q        <= '0;
            hi_q        <= '0;
            reps_q      <= '0;
            sweep_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            reps_q      <= reps_d;
            sweep_cnt_q <= sweep_cnt_d;
            err_q       <= err_d;
        end
    end

`ifdef COUNTER_SWEEP_DWELL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_q <= '0;
            ret_q   <= ST_IDLE;
        end else begin
            dwell_q <= dwell_d;
            ret_q   <= ret_d;
        end
    end
`endif

    // A reset cycle must not move the counter.
    assign cnt_en    = en_c & ~rst;
    assign cnt_up    = up_c;
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FINISH);
    assign err       = err_q;
    assign sweep_cnt = sweep_cnt_q;

endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
- Sequencer for the team's WIDTH-bit up/down counter (ports dout/clk/rst/en/up).
- Accepts a sweep command (lo, hi, reps) over a valid/ready handshake.
- Drives the counter's en/up and watches its dout to produce triangle sweeps lo→hi→lo, repeated reps times.
- Reports completion with a one-cycle done pulse; sits between a host/config FSM and the counter instance.

Parameters:
WIDTH, 8, counter/data width; must match the counter's width
REP_W, 4, width of the repetition count and of sweep_cnt

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  high only in IDLE
cmd_lo  input  WIDTH  sweep low bound
cmd_hi  input  WIDTH  sweep high bound
cmd_reps  input  REP_W  sweep count; 0 = run until abort
abort  input  1  terminate current command
cnt_val  input  WIDTH  counter dout
cnt_en  output  1  to counter en
cnt_up  output  1  to counter up (1=increment)
busy  output  1  state != IDLE
done  output  1  one-cycle completion pulse
err  output  1  valid with done; 1 = rejected or aborted
sweep_cnt  output  REP_W  completed sweeps of current command

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- Reset state:
  - state=IDLE; busy=0, done=0, err=0, sweep_cnt=0, cnt_en=0, cnt_up=1.
  - Counter contents are not touched.
- Accept:
  - Accept on the edge where cmd_valid&&cmd_ready; latch lo, hi, reps; clear sweep_cnt.
  - If lo>=hi: go to FINISH with err=1; cnt_en stays 0 throughout.
- FSM states: IDLE, SEEK, UP, DOWN, FINISH.
- Outputs: cnt_en/cnt_up are combinational from state and cnt_val (Mealy), so the counter stops on the exact compare cycle.
- SEEK:
  - cnt_val<lo: en=1, up=1.
  - cnt_val>lo: en=1, up=0.
  - cnt_val==lo: en=0, go to UP.
- UP:
  - cnt_val<hi: en=1, up=1.
  - cnt_val==hi: en=0, go to DOWN.
- DOWN:
  - cnt_val>lo: en=1, up=0.
  - cnt_val==lo: en=0, sweep_cnt+1.
  - Next state is FINISH if reps!=0 and sweep_cnt+1==reps; otherwise UP.
- Timing:
  - Each sweep is 2*(hi-lo)+2 cycles, i.e. one hold cycle at each turnaround.
  - SEEK is |start-lo|+1 cycles.
- FINISH: done=1, err per cause, cnt_en=0 for one cycle; then IDLE. err is cleared on next accept.
- sweep_cnt wraps modulo 2^REP_W when reps=0.
- Abort:
  - Abort in SEEK/UP/DOWN forces cnt_en=0 in that same cycle; next state is FINISH with err=1.
  - Abort has priority over natural completion in the same cycle.
  - Abort is ignored in IDLE and FINISH.
- Command while busy: not accepted (cmd_ready=0); a command held valid is accepted in the IDLE cycle after FINISH.
- Reset mid-operation: IDLE next edge, no done pulse, cnt_en=0.
- Unchanged cnt_val while cnt_en=1 is the external counter's responsibility; no timeout.

Optional Feature:
- Macro: COUNTER_SWEEP_DWELL_EN.
- Defined:
  - Adds input cmd_dwell[WIDTH-1:0], latched at accept.
  - Adds state DWELL, entered at each turnaround (UP→DOWN and DOWN→UP/FINISH).
  - DWELL holds cnt_en=0 for cmd_dwell extra cycles; dwell=0 equals baseline.
  - Abort in DWELL → FINISH err=1.
- Undefined: no port, no state; exact baseline timing.

Decomposition:
- Shared package counter_sweep_pkg:
  - State encoding constants (IDLE=0, SEEK=1, UP=2, DOWN=3, FINISH=4, DWELL=5).
  - Default WIDTH/REP_W.
- One sub-module, counter_sweep_dwell_tmr: loadable down-counter with a zero flag, instantiated only under COUNTER_SWEEP_DWELL_EN.
- Comparators and FSM stay in the top.

Test Plan:
- Bench wires the real up/down counter.
- 1. Counter at 0; cmd lo=10 hi=20 reps=2 → SEEK 11 cycles, sweeps 22 cycles each; done=1, err=0 on the 56th cycle after the accept edge; dout=10, sweep_cnt=2.
- 2. cmd lo=5 hi=5 reps=1 → done=1, err=1 on the cycle after accept; cnt_en never high; dout unchanged.
- 3. cmd lo=0 hi=255 reps=0 → dout triangles 0↔255 continuously; sweep_cnt wraps 15→0. Abort mid-UP → cnt_en=0 the same cycle, done+err next cycle, dout frozen.
- 4. Counter at 200; cmd lo=100 hi=150 reps=1 → SEEK counts down 100 cycles; done after 101+102 cycles; dout=100.
- 5. cmd_valid held during busy → cmd_ready=0, no relatch; new command accepted in the IDLE cycle right after the done pulse.
- 6. rst asserted during DOWN (dout=130) → next cycle IDLE, cnt_en=0, busy=0, no done; dout stays 130.
